// File: rtl/pow8_credit_buffer.sv
// pow8_credit_buffer: credit-gated FWFT FIFO absorbing the power-of-8 result stream.
module pow8_credit_buffer #(
  parameter int DEPTH = 8,
  parameter int DW = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_launch,
  output logic                       o_launch_ok,
  input  logic                       i_valid,
  input  logic [DW-1:0]              i_data,
  output logic                       o_valid,
  output logic [DW-1:0]              o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] inflight, inflight_nxt;
  logic push, pop, proto_hit;
  assign o_valid = o_count != '0;
  assign o_data = mem[rptr];
  assign pop = o_valid & i_ready;
  assign push = i_valid & ((o_count < FULL) | pop);
  // credits cover both stored and still-in-pipeline results
  assign o_launch_ok = ({1'b0, o_count} + {1'b0, inflight}) < {1'b0, FULL};
  assign inflight_nxt = (i_launch & ~i_valid) ? ((inflight == FULL) ? FULL : inflight + CW'(1))
                      : (i_valid & ~i_launch & (inflight != '0)) ? inflight - CW'(1)
                      : inflight;
  assign proto_hit = (i_launch & ~o_launch_ok) | (i_valid & ~i_launch & (inflight == '0));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      o_count <= '0;
      inflight <= '0;
      o_overflow <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      o_count <= o_count + CW'(push) - CW'(pop);
      inflight <= inflight_nxt;
      o_overflow <= o_overflow | (i_valid & ~push);
      o_proto_err <= o_proto_err | proto_hit;
    end
  end
  always_ff @(posedge clk) if (push) mem[wptr] <= i_data;
endmodule

// File: tb/tb_pow8_credit_buffer.sv
// tb_pow8_credit_buffer: vector table, directed corners and random traffic vs a queue model.
module tb_pow8_credit_buffer;
  localparam int DEPTH = 8;
  logic clk = 0, reset_n = 0, i_launch = 0, i_valid = 0, i_ready = 0;
  logic [63:0] i_data = '0;
  logic o_launch_ok, o_valid, o_overflow, o_proto_err;
  logic [63:0] o_data;
  logic [3:0] o_count;
  int vectors = 0, miscompares = 0;
  logic [63:0] mq[$];
  int m_inf = 0;
  bit m_ovf = 0, m_err = 0;

  pow8_credit_buffer #(.DEPTH(DEPTH), .DW(64)) dut (
    .clk(clk), .reset_n(reset_n), .i_launch(i_launch), .o_launch_ok(o_launch_ok),
    .i_valid(i_valid), .i_data(i_data), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_count(o_count), .o_overflow(o_overflow), .o_proto_err(o_proto_err));

  always #5 clk = ~clk;

  typedef struct {
    bit l, v; logic [63:0] d; bit r;
    int ecnt; bit evalid; bit eok; logic [63:0] edata;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit m_ok();
    return (mq.size() + m_inf) < DEPTH;
  endfunction

  task automatic check_model();
    chk("count", 64'(o_count), 64'(mq.size()));
    chk("valid", 64'(o_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("data", o_data, mq[0]);
    chk("launch_ok", 64'(o_launch_ok), 64'(m_ok()));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    chk("proto_err", 64'(o_proto_err), 64'(m_err));
  endtask

  task automatic model_update(input bit l, input bit v, input logic [63:0] d, input bit r);
    bit pop, push;
    pop = (mq.size() != 0) && r;
    push = v && (mq.size() < DEPTH || pop);
    if ((l && !m_ok()) || (v && !l && m_inf == 0)) m_err = 1;
    if (v && !push) m_ovf = 1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(d);
    if (l && !v) m_inf = (m_inf < DEPTH) ? m_inf + 1 : DEPTH;
    else if (v && !l && m_inf > 0) m_inf--;
  endtask

  task automatic step(input bit l, input bit v, input logic [63:0] d, input bit r);
    @(negedge clk);
    i_launch = l; i_valid = v; i_data = d; i_ready = r;
    #1;
    check_model();
    model_update(l, v, d, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; i_launch = 0; i_valid = 0; i_ready = 0;
    #1;
    mq.delete(); m_inf = 0; m_ovf = 0; m_err = 0;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_count", 64'(o_count), 64'(0));
    chk("rst_launch_ok", 64'(o_launch_ok), 64'(1));
    chk("rst_flags", 64'({o_overflow, o_proto_err}), 64'(0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1;
  endtask

  initial begin
    int launches;
    tbl[0] = '{1, 0, 64'h0, 1, 0, 0, 1, 64'h0};
    tbl[1] = '{0, 0, 64'h0, 1, 0, 0, 1, 64'h0};
    tbl[2] = '{0, 0, 64'h0, 1, 0, 0, 1, 64'h0};
    tbl[3] = '{0, 1, 64'h100, 1, 0, 0, 1, 64'h0};
    tbl[4] = '{0, 0, 64'h0, 1, 1, 1, 1, 64'h100};
    tbl[5] = '{0, 0, 64'h0, 1, 0, 0, 1, 64'h0};
    #1;
    chk("init_launch_ok", 64'(o_launch_ok), 64'(1));
    chk("init_valid", 64'(o_valid), 64'(0));
    do_reset();

    // single launch/result round trip
    foreach (tbl[i]) begin
      step(tbl[i].l, tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_count", i), 64'(o_count), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_valid", i), 64'(o_valid), 64'(tbl[i].evalid));
      chk($sformatf("tbl%0d_ok", i), 64'(o_launch_ok), 64'(tbl[i].eok));
      if (tbl[i].evalid) chk($sformatf("tbl%0d_data", i), o_data, tbl[i].edata);
    end
    step(0, 0, 0, 0);
    chk("single_inflight_zero", 64'(o_launch_ok && !o_proto_err), 64'(1));

    // credit limit, then full push+pop, then forced overflow
    do_reset();
    launches = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_ok()) launches++;
      step(m_ok(), 0, 0, 0);
    end
    chk("credit_launches", 64'(launches), 64'(DEPTH));
    for (int k = 0; k < DEPTH; k++) step(0, 1, 64'h1000 + 64'(k), 0);
    step(0, 0, 0, 0);
    chk("full_count", 64'(o_count), 64'(DEPTH));
    chk("full_flags", 64'({o_overflow, o_proto_err}), 64'(0));
    chk("full_ok", 64'(o_launch_ok), 64'(0));
    chk("full_head", o_data, 64'h1000);
    step(0, 1, 64'h1234, 1);
    step(0, 0, 0, 0);
    chk("pushpop_count", 64'(o_count), 64'(DEPTH));
    chk("pushpop_head", o_data, 64'h1001);
    chk("pushpop_ovf", 64'(o_overflow), 64'(0));
    step(0, 1, 64'hDEAD, 0);
    step(0, 0, 0, 0);
    chk("ovf_set", 64'(o_overflow), 64'(1));
    chk("ovf_count", 64'(o_count), 64'(DEPTH));
    for (int k = 0; k < DEPTH + 2; k++) begin
      step(0, 0, 0, 1);
      chk("no_dead", 64'(o_valid && o_data == 64'hDEAD), 64'(0));
    end
    chk("ovf_sticky", 64'(o_overflow), 64'(1));

    // launch without credit
    do_reset();
    for (int c = 0; c < DEPTH; c++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("proto_launch", 64'(o_proto_err), 64'(1));

    // result without any launch
    do_reset();
    step(0, 1, 64'h55, 0);
    step(0, 0, 0, 0);
    chk("proto_valid", 64'(o_proto_err), 64'(1));
    chk("proto_valid_data", o_data, 64'h55);

    // reset mid-stream with count 5, inflight 2
    do_reset();
    for (int c = 0; c < 7; c++) step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 64'h200 + 64'(k), 0);
    step(0, 0, 0, 0);
    chk("mid_count5", 64'(o_count), 64'(5));
    do_reset();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bit l, v;
      l = ($urandom_range(0, 9) < 5) && (m_ok() || $urandom_range(0, 39) == 0);
      v = (m_inf > 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 99) == 0;
      step(l, v, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
      if (c % 600 == 599) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
